display_select_ctrl: RTL and testbench

Pushbutton-driven selector that generates the 5-bit `Display_Select` code and the `Display_Enable` blanking control consumed by the processor's display debugger mux. It conditions the board pushbuttons (synchronise, debounce, edge-detect) and steps the selection up or down with wrap-around. An optional auto-scroll timer cycles through the views hands-free during demos.

---
 rtl/display_select_ctrl.sv | 173 +++++++++++++++++
 tb/tb_display_select_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_select_ctrl.sv
// Pushbutton-driven display selector: synchronise, debounce and edge-detect two buttons, then step a wrapping 5-bit code.
// Optional auto-scroll timer is built only when DISPLAY_AUTO_SCROLL_EN is defined.
module display_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SEL_MAX         = 21,
  parameter int SCROLL_CYCLES   = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Button_Up_n,
  input  logic       Button_Down_n,
  input  logic       Display_Off,
  input  logic       Auto_Scroll,
  output logic [4:0] Display_Select,
  output logic       Display_Enable
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [4:0]      SEL_TOP  = 5'(SEL_MAX);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

  function automatic logic [4:0] step_up(input logic [4:0] v);
    return (v >= SEL_TOP) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] step_down(input logic [4:0] v);
    return (v == 5'd0) ? SEL_TOP : v - 5'd1;
  endfunction

  // Synchroniser stages; bit 0 = up, bit 1 = down (buttons active-low)
  logic [1:0] btn_p1, btn_p2;
  logic       off_p1, off_p2;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_p1 <= 2'b11;
      btn_p2 <= 2'b11;
      off_p1 <= 1'b0;
      off_p2 <= 1'b0;
    end else begin
      btn_p1 <= {Button_Down_n, Button_Up_n};
      btn_p2 <= btn_p1;
      off_p1 <= Display_Off;
      off_p2 <= off_p1;
    end
  end

  // Debounce FSMs
  db_state_t        db_state    [2];
  db_state_t        db_state_nx [2];
  logic [CNT_W-1:0] db_cnt      [2];
  logic [CNT_W-1:0] db_cnt_nx   [2];
  logic [1:0]       db_press;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        db_state[b] <= IDLE;
        db_cnt[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        db_state[b] <= db_state_nx[b];
        db_cnt[b]   <= db_cnt_nx[b];
      end
    end
  end

  always_comb begin
    db_press = 2'b00;
    for (int b = 0; b < 2; b++) begin
      db_state_nx[b] = db_state[b];
      db_cnt_nx[b]   = db_cnt[b];
      case (db_state[b])
        IDLE: begin
          if (!btn_p2[b]) begin
            db_state_nx[b] = PRESS_WAIT;
            db_cnt_nx[b]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (btn_p2[b]) begin
            db_state_nx[b] = IDLE;
            db_cnt_nx[b]   = '0;
          end else if (db_cnt[b] == CNT_DONE) begin
            db_state_nx[b] = PRESSED;
            db_press[b]    = 1'b1;
          end else begin
            db_cnt_nx[b] = db_cnt[b] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (btn_p2[b]) begin
            db_state_nx[b] = RELEASE_WAIT;
            db_cnt_nx[b]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!btn_p2[b]) begin
            db_state_nx[b] = PRESSED;
          end else if (db_cnt[b] == CNT_DONE) begin
            db_state_nx[b] = IDLE;
          end else begin
            db_cnt_nx[b] = db_cnt[b] + CNT_W'(1);
          end
        end
        default: begin
          db_state_nx[b] = IDLE;
          db_cnt_nx[b]   = '0;
        end
      endcase
    end
  end

  logic tick;

`ifdef DISPLAY_AUTO_SCROLL_EN
  localparam int              TMR_W    = $clog2(SCROLL_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCROLL_CYCLES - 1);

  // auto_p3 holds the previous synchronised level for rise detection
  logic             auto_p1, auto_p2, auto_p3;
  logic [TMR_W-1:0] tmr;
  logic             restart;

  assign restart = (auto_p2 & ~auto_p3) | (|db_press);
  assign tick    = auto_p2 & ~restart & (tmr == TMR_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      auto_p1 <= 1'b0;
      auto_p2 <= 1'b0;
      auto_p3 <= 1'b0;
      tmr     <= '0;
    end else begin
      auto_p1 <= Auto_Scroll;
      auto_p2 <= auto_p1;
      auto_p3 <= auto_p2;
      if (!auto_p2 || restart || tick) tmr <= '0;
      else                             tmr <= tmr + TMR_W'(1);
    end
  end
`else
  logic unused_auto_scroll;

  assign tick               = 1'b0;
  assign unused_auto_scroll = Auto_Scroll | (SCROLL_CYCLES == 0);
`endif

  // Selection register; buttons take priority over a coincident scroll tick
  logic [4:0] sel_nx;

  always_comb begin
    sel_nx = Display_Select;
    if (db_press[0] && db_press[1]) sel_nx = 5'd0;
    else if (db_press[0])           sel_nx = step_up(Display_Select);
    else if (db_press[1])           sel_nx = step_down(Display_Select);
    else if (tick)                  sel_nx = step_up(Display_Select);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Display_Select <= 5'd0;
      Display_Enable <= 1'b0;
    end else begin
      Display_Select <= sel_nx;
      Display_Enable <= off_p2;
    end
  end

endmodule

// File: tb/tb_display_select_ctrl.sv
// Randomised and directed bench for display_select_ctrl with a run-length behavioural model.
module tb_display_select_ctrl;

  localparam int D    = 4;
  localparam int SMAX = 21;
  localparam int SC   = 10;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Button_Up_n = 1'b1;
  logic       Button_Down_n = 1'b1;
  logic       Display_Off = 1'b0;
  logic       Auto_Scroll = 1'b0;
  logic [4:0] Display_Select;
  logic       Display_Enable;

  display_select_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SEL_MAX        (SMAX),
    .SCROLL_CYCLES  (SC)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Button_Up_n   (Button_Up_n),
    .Button_Down_n (Button_Down_n),
    .Display_Off   (Display_Off),
    .Auto_Scroll   (Auto_Scroll),
    .Display_Select(Display_Select),
    .Display_Enable(Display_Enable)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
  endtask

  // Model: a button's accepted state flips once its synchronised level has
  // disagreed with it for D+2 consecutive clocks; a flip to pressed is a pulse.
  bit acc [2] = '{0, 0};
  int run [2] = '{0, 0};
  bit bh1 [2] = '{1, 1};
  bit bh2 [2] = '{1, 1};
  bit oh1 = 0, oh2 = 0;
  int exp_sel = 0;
  bit exp_en = 0;
`ifdef DISPLAY_AUTO_SCROLL_EN
  bit ah1 = 0, ah2 = 0, ah3 = 0;
  int edge_n = 0;
  int last_restart = 0;
`endif

  function automatic int inc_wrap(input int v);
    return (v == SMAX) ? 0 : v + 1;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        acc[b] = 0; run[b] = 0; bh1[b] = 1; bh2[b] = 1;
      end
      oh1 = 0; oh2 = 0; exp_sel = 0; exp_en = 0;
`ifdef DISPLAY_AUTO_SCROLL_EN
      ah1 = 0; ah2 = 0; ah3 = 0;
`endif
    end else begin : mdl
      bit [1:0] p;
      bit       tick;
      bit       want;
      p = 2'b00;
      tick = 0;
      for (int b = 0; b < 2; b++) begin
        want = acc[b] ? 1'b0 : 1'b1;
        if (bh2[b] != want) begin
          run[b]++;
          if (run[b] == D + 2) begin
            acc[b] = !acc[b];
            run[b] = 0;
            p[b]   = acc[b];
          end
        end else begin
          run[b] = 0;
        end
      end
`ifdef DISPLAY_AUTO_SCROLL_EN
      edge_n++;
      begin : scr
        bit rise;
        rise = ah2 && !ah3;
        if (ah2 && !rise && p == 2'b00 && edge_n > last_restart &&
            (edge_n - last_restart) % SC == 0) tick = 1;
        if (rise || p != 2'b00) last_restart = edge_n;
      end
      ah3 = ah2; ah2 = ah1; ah1 = Auto_Scroll;
`endif
      if (p == 2'b11)      exp_sel = 0;
      else if (p[0])       exp_sel = inc_wrap(exp_sel);
      else if (p[1])       exp_sel = (exp_sel == 0) ? SMAX : exp_sel - 1;
      else if (tick)       exp_sel = inc_wrap(exp_sel);
      exp_en = oh2;
      bh2[0] = bh1[0]; bh1[0] = Button_Up_n;
      bh2[1] = bh1[1]; bh1[1] = Button_Down_n;
      oh2 = oh1; oh1 = Display_Off;
    end
  end

  always @(negedge Clock) begin
    check("sel_vs_model", Display_Select, exp_sel);
    check("en_vs_model", Display_Enable, exp_en);
  end

  task automatic press(input bit up, input bit dn);
    @(negedge Clock);
    Button_Up_n = !up; Button_Down_n = !dn;
    repeat (D + 8) @(negedge Clock);
    Button_Up_n = 1'b1; Button_Down_n = 1'b1;
    repeat (D + 8) @(negedge Clock);
  endtask

  initial begin
    int up_left, dn_left;
    repeat (3) @(negedge Clock);
    check("reset_sel", Display_Select, 0);
    check("reset_en", Display_Enable, 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

    // single press: change exactly D+3 edges after first low sample
    @(negedge Clock); Button_Up_n = 1'b0;
    repeat (7) @(posedge Clock); #1;
    check("press_latency_minus1", Display_Select, 0);
    @(posedge Clock); #1;
    check("press_latency", Display_Select, 1);
    check("model_press_pin", exp_sel, 1);
    repeat (12) @(negedge Clock);
    Button_Up_n = 1'b1;
    repeat (12) @(negedge Clock);
    check("held_no_repeat", Display_Select, 1);

    // bounce shorter than debounce window
    @(negedge Clock); Button_Up_n = 1'b0;
    repeat (3) @(negedge Clock); Button_Up_n = 1'b1;
    @(negedge Clock); Button_Up_n = 1'b0;
    repeat (2) @(negedge Clock); Button_Up_n = 1'b1;
    repeat (12) @(negedge Clock);
    check("bounce_rejected", Display_Select, 1);

    // wrap both directions
    repeat (20) press(1, 0);
    check("reach_max", Display_Select, 21);
    press(1, 0);
    check("wrap_up", Display_Select, 0);
    press(0, 1);
    check("wrap_down", Display_Select, 21);
    check("model_wrap_pin", exp_sel, 21);

    // simultaneous press clears
    repeat (14) press(0, 1);
    check("at_seven", Display_Select, 7);
    @(negedge Clock); Button_Up_n = 1'b0; Button_Down_n = 1'b0;
    repeat (7) @(posedge Clock); #1;
    check("both_minus1", Display_Select, 7);
    @(posedge Clock); #1;
    check("both_clear", Display_Select, 0);
    repeat (6) @(negedge Clock);
    Button_Up_n = 1'b1; Button_Down_n = 1'b1;
    repeat (14) @(negedge Clock);

    // blanking latency, then reset in the middle of a debounce
    press(1, 0);
    @(negedge Clock); Display_Off = 1'b1;
    repeat (2) @(posedge Clock); #1;
    check("blank_edge2", Display_Enable, 0);
    @(posedge Clock); #1;
    check("blank_edge3", Display_Enable, 1);
    @(negedge Clock); Button_Up_n = 1'b0;
    repeat (4) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_sel", Display_Select, 0);
    check("async_reset_en", Display_Enable, 0);
    Button_Up_n = 1'b1;
    @(negedge Clock); #2 Reset = 1'b0;
    repeat (15) @(negedge Clock);
    check("press_lost", Display_Select, 0);
    Display_Off = 1'b0;
    repeat (4) @(negedge Clock);

`ifdef DISPLAY_AUTO_SCROLL_EN
    @(negedge Clock); Auto_Scroll = 1'b1;
    repeat (12) @(posedge Clock); #1;
    check("scroll_before_first", Display_Select, 0);
    @(posedge Clock); #1;
    check("scroll_1", Display_Select, 1);
    repeat (10) @(posedge Clock); #1;
    check("scroll_2", Display_Select, 2);
    repeat (10) @(posedge Clock); #1;
    check("scroll_3", Display_Select, 3);
    check("model_scroll_pin", exp_sel, 3);
    @(posedge Clock);
    @(negedge Clock); Button_Up_n = 1'b0;
    repeat (8) @(posedge Clock); #1;
    check("scroll_press", Display_Select, 4);
    repeat (9) @(posedge Clock); #1;
    check("tick_restarted", Display_Select, 4);
    @(posedge Clock); #1;
    check("tick_after_press", Display_Select, 5);
    @(negedge Clock); Button_Up_n = 1'b1; Auto_Scroll = 1'b0;
    repeat (14) @(negedge Clock);
`else
    @(negedge Clock); Auto_Scroll = 1'b1;
    repeat (100) @(negedge Clock);
    check("no_scroll_without_macro", Display_Select, 0);
    Auto_Scroll = 1'b0;
    repeat (4) @(negedge Clock);
`endif

    // randomised run-length stimulus
    up_left = 0; dn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      if (up_left == 0) begin
        Button_Up_n = 1'($urandom_range(0, 1));
        up_left = $urandom_range(1, 14);
      end
      up_left--;
      if (dn_left == 0) begin
        Button_Down_n = 1'($urandom_range(0, 1));
        dn_left = $urandom_range(1, 14);
      end
      dn_left--;
      if ($urandom_range(0, 19) == 0) Display_Off = ~Display_Off;
      if ($urandom_range(0, 149) == 0) Auto_Scroll = ~Auto_Scroll;
      if ($urandom_range(0, 499) == 0) begin
        #2 Reset = 1'b1;
        @(negedge Clock);
        #2 Reset = 1'b0;
      end
    end

    repeat (5) @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
